mem_arbiter: RTL and testbench

Two-requester arbiter that shares one external memory bus between the fetch path and the data path (`data_cache`) of the RV32I core. It accepts one transaction at a time, drives a registered request onto the bus, and waits for the bus completion. It then returns read data or write completion to the requester that owns the transaction. Data accesses take priority over fetch; a starvation counter bounds the number of consecutive data grants while a fetch waits.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between the instruction fetch
// path and the data path of the core. One transaction is outstanding at a
// time; data has priority over fetch, bounded by a starvation counter.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   if_req/if_addr/if_gnt      fetch request, address, combinational grant
//   if_rvalid/if_rdata         fetch data return (pulse / held data)
//   d_req/d_we/d_addr/d_wdata/d_be/d_gnt
//                              data request payload, combinational grant
//   d_rvalid/d_rdata           data completion pulse / held read data
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be
//                              registered memory-bus request fields
//   bus_ack/bus_rdata          memory completion pulse and read data
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transaction on the bus; grants may issue this cycle
// BUSY_IF | fetch transaction on the bus, waiting for bus_ack
// BUSY_D  | data transaction on the bus, waiting for bus_ack
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       sel_if;
  logic       sel_d;

  // Grants are combinational. They are also held low while rst_n is asserted
  // so every output reads 0 during reset, even with requests pending.
  always_comb begin
    sel_d  = 1'b0;
    sel_if = 1'b0;
    if (rst_n && state == IDLE) begin
      sel_d  = d_req && !(if_req && starve_cnt == STARVE_LIM);
      sel_if = if_req && !sel_d;
    end
  end

  assign if_gnt = sel_if;
  assign d_gnt  = sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          // bus_ack arriving here belongs to no transaction and is dropped.
          if (sel_d) begin
            state     <= BUSY_D;
            bus_req   <= 1'b1;
            bus_we    <= d_we;
            bus_addr  <= d_addr;
            bus_wdata <= d_we ? d_wdata : '0;
            bus_be    <= d_we ? d_be : '1;
            // Count only data grants that overtook a waiting fetch.
            if (if_req) begin
              if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= '0;
            end
          end else if (sel_if) begin
            state      <= BUSY_IF;
            bus_req    <= 1'b1;
            bus_we     <= 1'b0;
            bus_addr   <= if_addr;
            bus_wdata  <= '0;
            bus_be     <= '1;
            starve_cnt <= '0;
          end
        end
        BUSY_IF: begin
          if (bus_ack) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            if_rdata  <= bus_rdata;
            if_rvalid <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus_ack) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            d_rvalid <= 1'b1;
            if (!bus_we) d_rdata <= bus_rdata;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, bus_ack;
  logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, bus_req, bus_we;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by the bus: written words, otherwise an address hash.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E37_79B1;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] v;
    v = mem_read(a);
    for (int i = 0; i < 4; i++)
      if (be[i]) v[i*8 +: 8] = w[i*8 +: 8];
    mem[a] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},    32'(if_gnt),    0);
    chk({tag, "_d_gnt"},     32'(d_gnt),     0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, "_d_rvalid"},  32'(d_rvalid),  0);
    chk({tag, "_if_rdata"},  if_rdata,       0);
    chk({tag, "_d_rdata"},   d_rdata,        0);
    chk({tag, "_bus_req"},   32'(bus_req),   0);
    chk({tag, "_bus_we"},    32'(bus_we),    0);
    chk({tag, "_bus_addr"},  bus_addr,       0);
    chk({tag, "_bus_wdata"}, bus_wdata,      0);
    chk({tag, "_bus_be"},    32'(bus_be),    0);
    chk({tag, "_starve"},    32'(dut.starve_cnt), 0);
  endtask

  initial begin
    logic [5:0]  order_d;
    int          exp_sc [6];
    // random-phase model
    bit          idle_m, ack_prev, if_done, d_done, exp_we;
    int          owner, wait_m, cnt_m;
    logic [31:0] exp_rd, exp_addr, exp_wdata, exp_if_rdata, exp_d_rdata;
    logic [3:0]  exp_be;
    bit          exp_dg, exp_ig;

    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; bus_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; bus_rdata = 0;

    // ---- reset values ----
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ---- single fetch, ack 3 cycles after bus_req ----
    if_req = 1; if_addr = 32'h100;
    #1 chk("f_if_gnt", 32'(if_gnt), 1); chk("f_d_gnt", 32'(d_gnt), 0);
    @(negedge clk); if_req = 0;                                   // cycle 1
    chk("f_bus_req", 32'(bus_req), 1); chk("f_bus_addr", bus_addr, 32'h100);
    chk("f_bus_we", 32'(bus_we), 0); chk("f_bus_be", 32'(bus_be), 32'hF);
    chk("f_bus_wdata", bus_wdata, 0);
    @(negedge clk); chk("f_wait2", 32'(bus_req), 1);              // cycle 2
    @(negedge clk); chk("f_wait3", 32'(if_rvalid), 0);            // cycle 3
    @(negedge clk); bus_ack = 1; bus_rdata = 32'h0050_0093;       // cycle 4
    @(negedge clk); bus_ack = 0; bus_rdata = 0;                   // cycle 5
    chk("f_if_rvalid", 32'(if_rvalid), 1); chk("f_if_rdata", if_rdata, 32'h0050_0093);
    chk("f_bus_req_drop", 32'(bus_req), 0);
    @(negedge clk);
    chk("f_rvalid_pulse", 32'(if_rvalid), 0); chk("f_rdata_hold", if_rdata, 32'h0050_0093);

    // ---- data write, zero-wait ----
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    #1 chk("w_d_gnt", 32'(d_gnt), 1);
    @(negedge clk); d_req = 0; d_we = 0;
    chk("w_bus_we", 32'(bus_we), 1); chk("w_bus_addr", bus_addr, 32'h2000);
    chk("w_bus_wdata", bus_wdata, 32'hDEAD_BEEF); chk("w_bus_be", 32'(bus_be), 32'hF);
    bus_ack = 1; bus_rdata = 32'h1234_5678;
    @(negedge clk); bus_ack = 0;
    chk("w_d_rvalid", 32'(d_rvalid), 1); chk("w_d_rdata_kept", d_rdata, 0);

    // ---- priority and starvation: D D D D IF D ----
    order_d = 6'b101111;
    exp_sc = '{1, 2, 3, 4, 0, 0};
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk("prio_d_gnt", 32'(d_gnt), 32'(order_d[g]));
      chk("prio_if_gnt", 32'(if_gnt), 32'(!order_d[g]));
      @(negedge clk);
      if (!order_d[g]) if_req = 0;
      bus_ack = 1; bus_rdata = 32'hA000_0000 + 32'(g);
      #1;
      chk("prio_busy_nogrant", 32'({if_gnt, d_gnt}), 0);
      chk("prio_starve", 32'(dut.starve_cnt), 32'(exp_sc[g]));
      @(negedge clk); bus_ack = 0;
      chk("prio_rvalid", 32'(order_d[g] ? d_rvalid : if_rvalid), 1);
    end
    d_req = 0;
    @(negedge clk);

    // ---- data pulses every other window, fetch idle ----
    for (int k = 0; k < 4; k++) begin
      d_req = 1; d_we = 0; d_addr = 32'h500 + 32'(k * 4);
      #1 chk("pulse_d_gnt", 32'(d_gnt), 1);
      @(negedge clk); d_req = 0; bus_ack = 1; bus_rdata = 32'hC0DE_0000 + 32'(k);
      @(negedge clk); bus_ack = 0;
      chk("pulse_d_rvalid", 32'(d_rvalid), 1);
      chk("pulse_d_rdata", d_rdata, 32'hC0DE_0000 + 32'(k));
      chk("pulse_starve", 32'(dut.starve_cnt), 0);
      @(negedge clk);
    end

    // ---- reset in BUSY_D, then a late ack ----
    d_req = 1; d_we = 0; d_addr = 32'h600;
    #1 chk("rst_d_gnt", 32'(d_gnt), 1);
    @(negedge clk); d_addr = 32'h604;
    chk("rst_busy", 32'(bus_req), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk); rst_n = 1'b1; d_req = 0;
    @(negedge clk); bus_ack = 1; bus_rdata = 32'hBADB_AD00;
    @(negedge clk); bus_ack = 0;
    chk("late_d_rvalid", 32'(d_rvalid), 0); chk("late_if_rvalid", 32'(if_rvalid), 0);
    chk("late_d_rdata", d_rdata, 0); chk("late_bus_req", 32'(bus_req), 0);
    d_req = 1; d_addr = 32'h700;
    #1 chk("post_rst_gnt", 32'(d_gnt), 1);
    @(negedge clk); d_req = 0; bus_ack = 1; bus_rdata = 32'h7777_0001;
    @(negedge clk); bus_ack = 0;
    chk("post_rst_rdata", d_rdata, 32'h7777_0001);

    // ---- ack in IDLE with no requests ----
    bus_ack = 1; bus_rdata = 32'hFEED_FACE;
    @(negedge clk); bus_ack = 0; bus_rdata = 0;
    @(negedge clk);
    chk("idle_ack_rvalid", 32'({if_rvalid, d_rvalid}), 0);
    chk("idle_ack_if_rdata", if_rdata, 0);
    chk("idle_ack_d_rdata", d_rdata, 32'h7777_0001);
    chk("idle_ack_bus_req", 32'(bus_req), 0);

    // ---- randomized traffic against a memory / priority model ----
    idle_m = 1; ack_prev = 0; if_done = 0; d_done = 0; owner = 0; wait_m = 0;
    cnt_m = 0; exp_we = 0; exp_rd = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
    exp_if_rdata = 0; exp_d_rdata = 32'h7777_0001;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_if_rvalid", 32'(if_rvalid), 32'(ack_prev && owner == 1));
      chk("rnd_d_rvalid", 32'(d_rvalid), 32'(ack_prev && owner == 2));
      if (ack_prev) begin
        if (owner == 1) exp_if_rdata = exp_rd;
        if (owner == 2 && !exp_we) exp_d_rdata = exp_rd;
        owner = 0; idle_m = 1; ack_prev = 0; bus_ack = 0; bus_rdata = 0;
      end
      chk("rnd_if_rdata", if_rdata, exp_if_rdata);
      chk("rnd_d_rdata", d_rdata, exp_d_rdata);
      chk("rnd_bus_req", 32'(bus_req), 32'(owner != 0));
      chk("rnd_starve", 32'(dut.starve_cnt), 32'(cnt_m));
      if (owner != 0) begin
        chk("rnd_bus_addr", bus_addr, exp_addr);
        chk("rnd_bus_we", 32'(bus_we), 32'(exp_we));
        chk("rnd_bus_wdata", bus_wdata, exp_wdata);
        chk("rnd_bus_be", 32'(bus_be), 32'(exp_be));
        if (wait_m == 0) begin
          bus_ack = 1; ack_prev = 1;
          if (exp_we) begin
            mem_write(exp_addr, exp_wdata, exp_be);
            bus_rdata = $urandom;
          end else begin
            bus_rdata = exp_rd;
          end
        end else begin
          wait_m--;
        end
      end
      if (if_done) begin if_req = 0; if_done = 0; end
      if (d_done) begin d_req = 0; d_done = 0; end
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = {26'($urandom_range(0, 15)), 6'b0};
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = {26'($urandom_range(0, 15)), 6'b0};
        d_wdata = $urandom; d_be = 4'($urandom_range(1, 15));
      end
      #1;
      exp_dg = idle_m && d_req && !(if_req && cnt_m == SMAX);
      exp_ig = idle_m && if_req && !exp_dg;
      chk("rnd_d_gnt", 32'(d_gnt), 32'(exp_dg));
      chk("rnd_if_gnt", 32'(if_gnt), 32'(exp_ig));
      if (exp_dg) begin
        owner = 2; idle_m = 0; d_done = 1;
        exp_we = d_we; exp_addr = d_addr;
        exp_wdata = d_we ? d_wdata : 32'h0;
        exp_be = d_we ? d_be : 4'hF;
        exp_rd = mem_read(d_addr);
        cnt_m = if_req ? ((cnt_m < SMAX) ? cnt_m + 1 : SMAX) : 0;
        wait_m = $urandom_range(0, 3);
      end else if (exp_ig) begin
        owner = 1; idle_m = 0; if_done = 1;
        exp_we = 0; exp_addr = if_addr; exp_wdata = 0; exp_be = 4'hF;
        exp_rd = mem_read(if_addr);
        cnt_m = 0;
        wait_m = $urandom_range(0, 3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
